// File: rtl/vga_pkg.sv
// Shared display-RAM geometry, engine state encoding and command FIFO entry layout
// used by the frame-buffer writer, the VGA controller and the display RAM.
package vga_pkg;

    localparam int VGA_WIDTH      = 16;
    localparam int VGA_ADDR_WIDTH = 10;
    localparam int VGA_LEN_WIDTH  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } eng_state_t;

    // Entry layout at the default geometry; packed as {addr, data, len}, MSB first.
    typedef struct packed {
        logic [VGA_ADDR_WIDTH-1:0] addr;
        logic [VGA_WIDTH-1:0]      data;
        logic [VGA_LEN_WIDTH-1:0]  len;
    } fifo_entry_t;

    localparam int FIFO_ENTRY_W = $bits(fifo_entry_t);

    function automatic int entry_width(input int aw, input int dw, input int lw);
        return aw + dw + lw;
    endfunction

endpackage

// File: rtl/vga_fb_writer_if.sv
// Command bus from the processor side into the frame-buffer writer.
interface vga_fb_writer_if import vga_pkg::*; #(
    parameter int WIDTH      = VGA_WIDTH,
    parameter int ADDR_WIDTH = VGA_ADDR_WIDTH,
    parameter int LEN_WIDTH  = VGA_LEN_WIDTH
) ();

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [WIDTH-1:0]      cmd_data;
    logic [LEN_WIDTH-1:0]  cmd_len;

    modport master (
        output cmd_valid,
        output cmd_addr,
        output cmd_data,
        output cmd_len,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_addr,
        input  cmd_data,
        input  cmd_len,
        output cmd_ready
    );

endinterface

// File: rtl/vga_cmd_fifo.sv
// Small synchronous first-word-fall-through FIFO holding pending write/fill commands.
module vga_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 34
) (
    input  logic                   clk50MHz,
    input  logic                   clr,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DW-1:0]          din,
    output logic [DW-1:0]          dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] store [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign level   = count_reg;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = store[rd_ptr_reg];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk50MHz) begin
        if (!clr) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk50MHz) begin
        if (clr && do_push) store[wr_ptr_reg] <= din;
    end

endmodule

// File: rtl/vga_fb_writer.sv
// Write-side engine for the display RAM: queues write/fill commands and issues
// word writes only while the VGA controller is blanking.
module vga_fb_writer import vga_pkg::*; #(
    parameter int WIDTH      = VGA_WIDTH,
    parameter int ADDR_WIDTH = VGA_ADDR_WIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_WIDTH  = VGA_LEN_WIDTH
) (
    input  logic                        clk50MHz,
    input  logic                        clr,
    vga_fb_writer_if.slave              cmd,
    input  logic                        blank,
    output logic                        mem_we,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    output logic [WIDTH-1:0]            mem_wdata,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int EW = entry_width(ADDR_WIDTH, WIDTH, LEN_WIDTH);

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [EW-1:0]         fifo_din;
    logic [EW-1:0]         fifo_dout;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [WIDTH-1:0]      head_data;
    logic [LEN_WIDTH-1:0]  head_len;

    eng_state_t            state_reg;
    logic [ADDR_WIDTH-1:0] cur_addr_reg;
    logic [WIDTH-1:0]      cur_data_reg;
    logic [LEN_WIDTH-1:0]  remaining_reg;
    logic                  mem_we_reg;
    logic [ADDR_WIDTH-1:0] mem_addr_reg;
    logic [WIDTH-1:0]      mem_wdata_reg;

    assign cmd.cmd_ready = clr && !fifo_full;
    assign fifo_push     = cmd.cmd_valid && cmd.cmd_ready;
    assign fifo_din      = {cmd.cmd_addr, cmd.cmd_data, cmd.cmd_len};
    assign head_addr     = fifo_dout[EW-1 -: ADDR_WIDTH];
    assign head_data     = fifo_dout[LEN_WIDTH +: WIDTH];
    assign head_len      = fifo_dout[LEN_WIDTH-1:0];

    vga_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (EW)
    ) u_fifo (
        .clk50MHz (clk50MHz),
        .clr      (clr),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .din      (fifo_din),
        .dout     (fifo_dout),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    // Pop when idle, or when the last word of the current command issues so the
    // next command follows with no gap cycle.
    always_comb begin
        fifo_pop = 1'b0;
        if (!fifo_empty) begin
            if (state_reg == IDLE)
                fifo_pop = 1'b1;
            else if (blank && remaining_reg == '0)
                fifo_pop = 1'b1;
        end
    end

    always_ff @(posedge clk50MHz) begin
        if (!clr) begin
            state_reg     <= IDLE;
            cur_addr_reg  <= '0;
            cur_data_reg  <= '0;
            remaining_reg <= '0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            mem_we_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (fifo_pop) begin
                        cur_addr_reg  <= head_addr;
                        cur_data_reg  <= head_data;
                        remaining_reg <= head_len;
                        state_reg     <= WRITE;
                    end
                end
                WRITE: begin
                    // Outside blanking every counter holds, so a paused fill resumes
                    // at the first un-issued address.
                    if (blank) begin
                        mem_we_reg    <= 1'b1;
                        mem_addr_reg  <= cur_addr_reg;
                        mem_wdata_reg <= cur_data_reg;
                        if (remaining_reg == '0) begin
                            if (fifo_pop) begin
                                cur_addr_reg  <= head_addr;
                                cur_data_reg  <= head_data;
                                remaining_reg <= head_len;
                            end else begin
                                state_reg <= IDLE;
                            end
                        end else begin
                            cur_addr_reg  <= cur_addr_reg + ADDR_WIDTH'(1);
                            remaining_reg <= remaining_reg - LEN_WIDTH'(1);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign busy      = (state_reg != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_vga_fb_writer.sv
// Randomized scoreboard bench for vga_fb_writer: accepted commands expand into
// expected RAM writes, and a monitor checks every issued write against them.
module tb_vga_fb_writer;
    import vga_pkg::*;

    localparam int AW    = 10;
    localparam int DW    = 16;
    localparam int LW    = 8;
    localparam int DEPTH = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic                    clk50MHz = 1'b0;
    logic                    clr      = 1'b0;
    logic                    blank    = 1'b1;
    logic                    blank_q  = 1'b0;
    logic                    mem_we;
    logic [AW-1:0]           mem_addr;
    logic [DW-1:0]           mem_wdata;
    logic                    busy;
    logic [$clog2(DEPTH):0]  fifo_level;

    int  checks      = 0;
    int  errors      = 0;
    int  writes_seen = 0;
    int  blank_mode  = 1;   // 0: held low, 1: held high, 2: random per cycle
    wr_t exp_q[$];
    wr_t mon_e;

    vga_fb_writer_if #(.WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) cmd_bus ();

    vga_fb_writer #(
        .WIDTH      (DW),
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (DEPTH),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk50MHz   (clk50MHz),
        .clr        (clr),
        .cmd        (cmd_bus),
        .blank      (blank),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    always #10 clk50MHz = ~clk50MHz;

    always @(posedge clk50MHz) blank_q <= blank;

    initial begin
        forever begin
            @(posedge clk50MHz);
            #1;
            case (blank_mode)
                0:       blank = 1'b0;
                1:       blank = 1'b1;
                default: blank = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Every issued write must be the next expected one and must follow a blanking edge.
    always @(negedge clk50MHz) begin
        if (mem_we === 1'b1) begin
            writes_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected got addr=%h data=%h required=no write", mem_addr, mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (mem_addr !== mon_e.addr || mem_wdata !== mon_e.data || blank_q !== 1'b1) begin
                    errors++;
                    $display("FAIL write got addr=%h data=%h blank=%b required addr=%h data=%h blank=1",
                             mem_addr, mem_wdata, blank_q, mon_e.addr, mon_e.data);
                end else begin
                    $display("write addr=%h data=%h ok", mem_addr, mem_wdata);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    // Offers one command, holds it until accepted, then records the writes it implies.
    task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [LW-1:0] l);
        bit  acc;
        int  t;
        wr_t w;
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_addr  = a;
        cmd_bus.cmd_data  = d;
        cmd_bus.cmd_len   = l;
        acc = 1'b0;
        t   = 0;
        while (!acc && t < 2000) begin
            @(negedge clk50MHz);
            acc = cmd_bus.cmd_ready;
            @(posedge clk50MHz);
            t++;
        end
        if (acc) begin
            for (int i = 0; i <= int'(l); i++) begin
                w.addr = AW'(int'(a) + i);
                w.data = d;
                exp_q.push_back(w);
            end
            $display("cmd addr=%h data=%h len=%0d accepted", a, d, l);
        end else begin
            checks++;
            errors++;
            $display("FAIL send_timeout got=not accepted required=accepted addr=%h", a);
        end
        #1;
        cmd_bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while ((busy || exp_q.size() != 0) && t < 3000) begin
            @(negedge clk50MHz);
            t++;
        end
        chk(name, 32'(t < 3000), 32'd1);
        @(posedge clk50MHz);
        #1;
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int t;
        int run;
        int n_before;

        // Reset held for two edges with a command offered.
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_addr  = '0;
        cmd_bus.cmd_data  = '0;
        cmd_bus.cmd_len   = '0;
        repeat (2) begin
            @(negedge clk50MHz);
            chk("rst_ready", 32'(cmd_bus.cmd_ready), 32'd0);
            chk("rst_we", 32'(mem_we), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_level", 32'(fifo_level), 32'd0);
        end
        @(posedge clk50MHz);
        #1;
        clr = 1'b1;
        cmd_bus.cmd_valid = 1'b0;
        @(negedge clk50MHz);
        chk("ready_after_rst", 32'(cmd_bus.cmd_ready), 32'd1);
        @(posedge clk50MHz);
        #1;

        // Single write latency: accept at N, write visible after N+2 for one cycle.
        send(10'h100, 16'h0001, 8'd0);
        @(negedge clk50MHz);
        chk("lat_after_n", 32'(mem_we), 32'd0);
        @(negedge clk50MHz);
        chk("lat_after_n1", 32'(mem_we), 32'd0);
        @(negedge clk50MHz);
        chk("lat_we", 32'(mem_we), 32'd1);
        chk("lat_addr", 32'(mem_addr), 32'h100);
        chk("lat_data", 32'(mem_wdata), 32'h0001);
        @(negedge clk50MHz);
        chk("single_we_drop", 32'(mem_we), 32'd0);
        chk("single_busy", 32'(busy), 32'd0);
        @(posedge clk50MHz);
        #1;

        // Fill across the top of the address space.
        base = writes_seen;
        send(10'h3FE, 16'hABCD, 8'd3);
        wait_idle("wrap_idle");
        chk("wrap_count", 32'(writes_seen - base), 32'd4);

        // Fill under random blanking.
        blank_mode = 2;
        base = writes_seen;
        send(10'h010, 16'h5A5A, 8'd4);
        wait_idle("gate_idle");
        chk("gate_count", 32'(writes_seen - base), 32'd5);

        // Backpressure with blanking held low, then release.
        blank_mode = 0;
        repeat (2) @(posedge clk50MHz);
        #1;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(AW'(10'h300 + i), DW'(16'h0010 + i), 8'd0);
            end
            begin
                repeat (10) @(negedge clk50MHz);
                chk("bp_level", 32'(fifo_level), 32'(DEPTH));
                chk("bp_ready", 32'(cmd_bus.cmd_ready), 32'd0);
                chk("bp_no_we", 32'(mem_we), 32'd0);
                chk("bp_busy", 32'(busy), 32'd1);
                blank_mode = 1;
                t = 0;
                while (!mem_we && t < 50) begin
                    @(negedge clk50MHz);
                    t++;
                end
                run = 0;
                while (mem_we && run < 20) begin
                    run++;
                    @(negedge clk50MHz);
                end
                chk("bp_run", 32'(run), 32'd6);
            end
        join
        wait_idle("bp_idle");

        // Random commands under random blanking, then a maximum-length fill.
        blank_mode = 2;
        for (int n = 0; n < 20; n++) begin
            send(AW'($urandom_range(0, 1023)), DW'($urandom), LW'($urandom_range(0, 6)));
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk50MHz);
                #1;
            end
        end
        wait_idle("rand_idle");
        blank_mode = 1;
        base = writes_seen;
        send(10'h3F0, 16'hBEEF, 8'hFF);
        wait_idle("max_idle");
        chk("max_count", 32'(writes_seen - base), 32'd256);

        // Reset in the middle of a fill with two commands queued behind it.
        base = writes_seen;
        send(10'h200, 16'h7777, 8'd9);
        send(10'h280, 16'h0001, 8'd2);
        send(10'h290, 16'h0002, 8'd0);
        t = 0;
        while ((writes_seen - base) < 3 && t < 50) begin
            @(negedge clk50MHz);
            #1;
            t++;
        end
        chk("mf_three_writes", 32'(writes_seen - base), 32'd3);
        chk("mf_queued", 32'(fifo_level), 32'd2);
        clr = 1'b0;
        @(posedge clk50MHz);
        #1;
        clr = 1'b1;
        exp_q.delete();
        n_before = writes_seen;
        @(negedge clk50MHz);
        chk("mf_level", 32'(fifo_level), 32'd0);
        chk("mf_busy", 32'(busy), 32'd0);
        chk("mf_we", 32'(mem_we), 32'd0);
        repeat (10) @(negedge clk50MHz);
        chk("mf_no_more_writes", 32'(writes_seen - n_before), 32'd0);
        @(posedge clk50MHz);
        #1;

        // Engine is usable again after the abort.
        base = writes_seen;
        send(10'h050, 16'h1234, 8'd1);
        wait_idle("post_rst_idle");
        chk("post_rst_count", 32'(writes_seen - base), 32'd2);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
